// File: rtl/led_fade_driver.sv
// led_fade_driver: PWM fade stage placed between the 4-LED chaser and the
// board LED pins. Each channel ramps its duty linearly toward full-on or
// full-off, one step per step_tick, and a single shared PWM counter turns
// the brightness of every channel into an active-low pin drive.
//
// Build option: define LED_FADE_GAMMA_EN to map duty through a quadratic
// curve, (duty*duty) >> PWM_BITS, with full scale kept at full scale.
// Without the macro, brightness equals duty. Ramp timing and busy behave
// the same way in both builds.
module led_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 19531,
    parameter int N_CH     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pattern_n,
    input  logic            enable,
    output logic [N_CH-1:0] led_n,
    output logic            busy
);

    // The step counter needs at least one bit, even for STEP_DIV == 1.
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
    // The PWM counter stops one short of full scale. As a result, a
    // brightness of DUTY_MAX is greater than every counter value, so the
    // LED stays lit for the whole period.
    localparam logic [PWM_BITS-1:0] PWM_LAST = DUTY_MAX - DUTY_ONE;
    localparam logic [STEP_W-1:0]   STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [N_CH-1:0]     sync_p0;
    logic [N_CH-1:0]     pat_s;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] target [N_CH];
    logic [PWM_BITS-1:0] duty   [N_CH];
    logic [PWM_BITS-1:0] bright [N_CH];
    logic [N_CH-1:0]     on;
    logic [N_CH-1:0]     mismatch;

    // Move duty one step toward the target and hold it once equal.
    // Because duty only moves toward a value that is in range, it cannot
    // wrap.
    function automatic logic [PWM_BITS-1:0] ramp_step(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + DUTY_ONE;
        end
        if (cur > tgt) begin
            return cur - DUTY_ONE;
        end
        return cur;
    endfunction

`ifdef LED_FADE_GAMMA_EN
    // Quadratic perceptual curve: keep the upper half of the
    // double-width square. Full scale maps straight to full scale, so a
    // finished up-ramp still drives the LED fully on.
    function automatic logic [PWM_BITS-1:0] gamma_map(
        input logic [PWM_BITS-1:0] d
    );
        if (d == DUTY_MAX) begin
            return DUTY_MAX;
        end
        return PWM_BITS'(({{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d}) >> PWM_BITS);
    endfunction
`endif

    // Two-flop synchroniser for the chaser pattern. It resets to "all off".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '1;
            pat_s   <= '1;
        end else begin
            sync_p0 <= pattern_n;
            pat_s   <= sync_p0;
        end
    end

    // A channel that is requested on targets full scale; every other
    // channel targets zero.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            target[i] = pat_s[i] ? '0 : DUTY_MAX;
        end
    end

    // Shared PWM counter. Its period is 2^PWM_BITS-1 clocks, and it is
    // held at zero while the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
        end
    end

    // Prescaler that sets the ramp rate. It is held at zero while the
    // block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (!enable) begin
            step_cnt <= '0;
        end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + STEP_ONE;
        end
    end

    assign step_tick = enable && (step_cnt == STEP_LAST);

    // Duty ramps. Disabling takes priority over a coincident tick. A
    // target that reverses simply changes the direction of the next step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                duty[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < N_CH; i++) begin
                duty[i] <= '0;
            end
        end else if (step_tick) begin
            for (int i = 0; i < N_CH; i++) begin
                duty[i] <= ramp_step(duty[i], target[i]);
            end
        end
    end

    // Brightness mapping, PWM compare and settle detection per channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef LED_FADE_GAMMA_EN
            bright[i] = gamma_map(duty[i]);
`else
            bright[i] = duty[i];
`endif
            on[i]       = bright[i] > pwm_cnt;
            mismatch[i] = duty[i] != target[i];
        end
    end

    // Registered pin drive (active-low) and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_n <= '1;
            busy  <= 1'b0;
        end else begin
            led_n <= enable ? ~on : '1;
            busy  <= |mismatch;
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Testbench for led_fade_driver with small parameters, so that ramps and
// PWM periods stay short. A cycle-level reference model pushes the
// expected pin state for every clock into a queue, and a separate monitor
// pops each entry and compares it against the DUT shortly after the edge.
module tb_led_fade_driver;

    localparam int PW   = 4;
    localparam int SD   = 2;
    localparam int NC   = 4;
    localparam int DMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NC-1:0] pattern_n;
    logic [NC-1:0] led_n;
    logic          busy;

    typedef struct {
        logic [NC-1:0] led;
        logic          busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    // Reference model state
    int            m_duty [NC];
    int            m_en_cnt;
    logic [NC-1:0] m_hist0;
    logic [NC-1:0] m_hist1;

    led_fade_driver #(.PWM_BITS(PW), .STEP_DIV(SD), .N_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .pattern_n (pattern_n),
        .enable    (enable),
        .led_n     (led_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bright_of(input int d);
`ifdef LED_FADE_GAMMA_EN
        if (d == DMAX) return DMAX;
        return (d * d) / (1 << PW);
`else
        return d;
`endif
    endfunction

    // Model: on each edge, derive the pin state that follows from the
    // state before the edge, then advance to the next state.
    // pat_s is the pattern seen two edges earlier; the PWM phase and the
    // step phase are counts of enabled edges taken modulo their periods.
    always @(posedge clk) begin : model
        exp_t e;
        int   pwm;
        int   tgt;
        bit   tick;
        if (rst) begin
            for (int i = 0; i < NC; i++) m_duty[i] = 0;
            m_en_cnt = 0;
            m_hist0  = '1;
            m_hist1  = '1;
            e.led    = '1;
            e.busy   = 1'b0;
        end else begin
            pwm    = m_en_cnt % DMAX;
            tick   = enable && ((m_en_cnt % SD) == SD - 1);
            e.led  = '1;
            e.busy = 1'b0;
            for (int i = 0; i < NC; i++) begin
                tgt = m_hist1[i] ? 0 : DMAX;
                if (m_duty[i] != tgt) e.busy = 1'b1;
                if (enable && bright_of(m_duty[i]) > pwm) e.led[i] = 1'b0;
                if (!enable) m_duty[i] = 0;
                else if (tick && m_duty[i] < tgt) m_duty[i] = m_duty[i] + 1;
                else if (tick && m_duty[i] > tgt) m_duty[i] = m_duty[i] - 1;
            end
            m_en_cnt = enable ? m_en_cnt + 1 : 0;
            m_hist1  = m_hist0;
            m_hist0  = pattern_n;
        end
        if (mon_on) sb_q.push_back(e);
    end

    // Monitor: compare the DUT pins with the oldest expectation, 1 time
    // unit after each edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (mon_on) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("led_n", 32'(led_n), 32'(e.led));
                chk("busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the model's channel-0 duty equals val.
    task automatic wait_duty0(input int val, input int budget, input string name);
        int k;
        k = 0;
        while (m_duty[0] != val && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(m_duty[0] == val), 32'd1);
    endtask

    initial begin : stim
        int lit;
        rst       = 1'b0;
        enable    = 1'b1;
        pattern_n = 4'b1110;
        #1 rst = 1'b1;
        #1;
        // The asynchronous reset takes effect before any clock edge.
        chk("reset_led_async", 32'(led_n), 32'hF);
        chk("reset_busy_async", 32'(busy), 32'h0);
        mon_on = 1'b1;
        cycles(3);
        rst = 1'b0;

        // Ramp channel 0 up to full, then check that it stays lit.
        wait_duty0(DMAX, 100, "ramp_up_reached");
        cycles(4);
        lit = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (led_n == 4'b1110) lit++;
        end
        chk("full_on_constant", 32'(lit), 32'd30);
        @(negedge clk);

        // Ramp down fully, ramp back up, and reverse at duty 7.
        pattern_n = 4'b1111;
        wait_duty0(0, 100, "ramp_down_reached");
        pattern_n = 4'b1110;
        wait_duty0(7, 100, "ramp_mid_reached");
        pattern_n = 4'b1111;
        wait_duty0(0, 100, "reversal_reached_zero");
        cycles(20);

        // Disable in the middle of a ramp; the pins go dark on the next edge.
        pattern_n = 4'b0000;
        wait_duty0(6, 100, "all_ramp_mid");
        enable = 1'b0;
        @(posedge clk); #2;
        chk("disable_dark", 32'(led_n), 32'hF);
        @(negedge clk);
        cycles(5);
        enable = 1'b1;
        wait_duty0(9, 100, "restart_ramp");

        // Assert an asynchronous reset in the middle of a ramp.
        #2 rst = 1'b1;
        #1;
        chk("midramp_reset_led", 32'(led_n), 32'hF);
        chk("midramp_reset_busy", 32'(busy), 32'h0);
        cycles(3);
        rst = 1'b0;
        cycles(40);

        // Random patterns, enable toggles and reset pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if ($urandom_range(0, 9) == 0) pattern_n = 4'($urandom);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
        end
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        cycles(10);

        mon_on = 1'b0;
        @(posedge clk); #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream stage of the 4-LED chaser. It consumes the chaser's active-low 4-bit LED pattern and drives the board LED pins.
- Each LED fades up or down on a linear brightness ramp instead of switching hard.
- Brightness is produced with a shared PWM counter and one duty register per channel.
- Sits between the chaser output and the top-level LED pins, in the same clock domain.

Parameters:
- PWM_BITS, 8, width of the PWM counter and of each duty register. PWM period = 2^PWM_BITS-1 clocks.
- STEP_DIV, 19531, clocks per brightness step. At the default, a full 0->255 ramp takes about 100 ms at 50 MHz.
- N_CH, 4, number of LED channels.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pattern_n  input  N_CH  LED pattern from the chaser. Active-low: bit=0 means the LED is requested on.
- enable  input  1  1 = normal operation; 0 = all LEDs dark and ramps cleared.
- led_n  output  N_CH  PWM LED drive, active-low, registered.
- busy  output  1  1 while any channel's duty differs from its target. Registered.

Behaviour:
- Reset (asynchronous, rst=1):
  - led_n = all ones; busy = 0.
  - All duty registers = 0; pwm_cnt = 0; step_cnt = 0.
  - Synchroniser flops = all ones.
- Input sync: pattern_n passes through a 2-flop synchroniser giving pat_s. The target changes 2 clocks after pattern_n changes.
- Target per channel: target[i] = (pat_s[i]==0) ? 2^PWM_BITS-1 : 0.
- PWM counter: pwm_cnt counts 0..2^PWM_BITS-2, then wraps to 0 (period 2^PWM_BITS-1 clocks).
- Step counter: step_cnt counts 0..STEP_DIV-1. step_tick is asserted for one clock when step_cnt == STEP_DIV-1, and step_cnt wraps to 0.
- Duty update, on step_tick only:
  - duty[i] < target[i] -> duty[i] + 1.
  - duty[i] > target[i] -> duty[i] - 1.
  - Equal -> hold.
  - No overflow or underflow is possible; duty saturates at the target.
- Target reversal mid-ramp: the ramp reverses direction from the current duty on the next step_tick. No jump.
- Output: on = (bright[i] > pwm_cnt); led_n[i] <= ~on, registered (1 clock after the compare).
  - bright = 0 -> always dark.
  - bright = 2^PWM_BITS-1 -> always lit.
- busy: registered; set when any duty[i] != target[i]. It reflects the compare from the previous cycle.
- enable = 0:
  - led_n forced to all ones on the next clock.
  - All duties cleared to 0; pwm_cnt and step_cnt held at 0.
- enable rising edge: the counters restart from 0, and ramps start from 0 toward the current target.
- Simultaneous enable=0 and step_tick: enable wins, and duties go to 0.
- Reset asserted mid-ramp: all state clears immediately and asynchronously. After release, operation restarts from duty 0.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: bright[i] = (duty[i]*duty[i]) >> PWM_BITS, using a 2*PWM_BITS-bit product with the upper PWM_BITS bits taken. This gives a perceptual (quadratic) ramp.
  - Full-scale exception: duty = 2^PWM_BITS-1 is forced to bright = 2^PWM_BITS-1, so the LED is fully lit.
- Not defined: bright[i] = duty[i] (linear).
- busy, ramp timing and duty behaviour are identical in both builds.

Test Plan:
Bench parameters: PWM_BITS=4, STEP_DIV=2, N_CH=4, linear build unless stated.
1. Reset: hold rst=1 with pattern_n=4'b1110 -> led_n=4'hF, busy=0; after release, busy=1 from the 4th clock.
2. Ramp up: pattern_n=4'b1110, enable=1 -> duty[0] reaches 15 after 15 step_ticks (30 clocks + sync). led_n[0] is then constant 0, busy=0, and led_n[3:1] stay 1.
3. Mid-ramp reversal: change pattern_n to 4'b1111 when duty[0]=7 -> next tick duty[0]=6; it reaches 0 after 7 ticks and led_n[0] is constant 1.
4. PWM duty: freeze duty[0]=5 by stopping ticks (force test) -> led_n[0] is low for exactly 5 of every 15 clocks.
5. Disable: enable=0 mid-ramp -> next clock led_n=4'hF, duties=0. enable=1 -> ramps restart from 0.
6. Gamma build (LED_FADE_GAMMA_EN): duty=8 -> bright 4 (4/15 low). Duty=15 -> led_n[0] constant 0.
